d_debounce_edge: RTL and testbench

Single-bit conditioning stage that sits directly downstream of d_flip_flop and takes its registered q output as din. It filters out pulses shorter than STABLE_CYCLES clocks and presents a debounced level. It also produces one-cycle rise and fall strobes for downstream control logic. All logic runs on one clock, and din needs no further synchronisation because it is already a registered signal in the clk domain.

---
 rtl/d_debounce_edge.sv | 108 ++++++++++
 tb/tb_d_debounce_edge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_debounce_edge.sv
// Debounces a registered single-bit level and emits one-cycle rise/fall
// strobes when a new level has held for STABLE_CYCLES consecutive samples.
module d_debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q_level,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    S_LOW,
    S_LOW_CHK,
    S_HIGH,
    S_HIGH_CHK
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_LEVEL ? S_HIGH : S_LOW;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // cnt holds the number of consecutive candidate samples seen so far
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (din) begin
          state_d = S_LOW_CHK;
          cnt_d   = ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_LOW_CHK: begin
        if (!din) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_HIGH: begin
        if (!din) begin
          state_d = S_HIGH_CHK;
          cnt_d   = ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_HIGH_CHK: begin
        if (din) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = S_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
  end

  assign q_level = level_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign busy    = (state_q == S_LOW_CHK) ||
                   (state_q == S_HIGH_CHK);

endmodule

// File: tb/tb_d_debounce_edge.sv
// Directed bench for d_debounce_edge with STABLE_CYCLES=4, RESET_LEVEL=0,
// including a chained run behind a modelled d flip-flop.
module tb_d_debounce_edge;

  logic clk;
  logic reset;
  logic din;
  logic q_level;
  logic rise;
  logic fall;
  logic busy;

  logic chain;
  logic d;
  logic ffq;
  logic dut_din;
  logic [3:0] sh;

  int total;
  int bad;

  assign dut_din = chain ? ffq : din;

  d_debounce_edge #(
    .STABLE_CYCLES(4),
    .CNT_W(8),
    .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din(dut_din),
    .q_level(q_level),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // flop upstream of the debouncer, plus a history of sampled din
  always @(posedge clk) begin
    ffq <= d;
    sh  <= {sh[2:0], dut_din};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v);
    @(negedge clk);
    din = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i[0]);
      tick();
      total += 4;
      if (q_level !== 1'b0) begin
        bad++;
        $display("FAIL reset_q cyc=%0d got=%b exp=0", i, q_level);
      end
      if (rise !== 1'b0) begin
        bad++;
        $display("FAIL reset_rise cyc=%0d got=%b exp=0", i, rise);
      end
      if (fall !== 1'b0) begin
        bad++;
        $display("FAIL reset_fall cyc=%0d got=%b exp=0", i, fall);
      end
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy);
      end
    end
  endtask

  // drives v for n samples from a stable state of ~v and checks the
  // accept/reject behaviour; returns with din still at v
  task automatic test_pulse(input string nm, input logic v, input int n);
    logic exp_q;
    int   strobes;
    strobes = 0;
    exp_q = ~v;
    @(negedge clk);
    reset = 1'b0;
    din = v;
    for (int e = 1; e <= n; e++) begin
      tick();
      if (e == 4) exp_q = v;
      strobes += int'(v ? rise : fall);
      total += 3;
      if (busy !== (e < 4)) begin
        bad++;
        $display("FAIL %s_busy edge=%0d got=%b exp=%b", nm, e, busy, e < 4);
      end
      if (q_level !== exp_q) begin
        bad++;
        $display("FAIL %s_q edge=%0d got=%b exp=%b", nm, e, q_level, exp_q);
      end
      if ((v ? fall : rise) !== 1'b0) begin
        bad++;
        $display("FAIL %s_wrong_strobe edge=%0d", nm, e);
      end
    end
    total++;
    if (strobes != ((n >= 4) ? 1 : 0)) begin
      bad++;
      $display("FAIL %s_strobes got=%0d exp=%0d", nm, strobes, (n >= 4) ? 1 : 0);
    end
  endtask

  task automatic test_clean_rise();
    test_pulse("rise", 1'b1, 5);
    total++;
    if (rise !== 1'b0) begin
      bad++;
      $display("FAIL rise_after got=%b exp=0", rise);
    end
  endtask

  task automatic test_clean_fall();
    test_pulse("fall", 1'b0, 5);
  endtask

  task automatic test_glitch();
    test_pulse("glitch_hi3", 1'b1, 3);
    drive(1'b0);
    tick();
    total += 2;
    if (busy !== 1'b0 || q_level !== 1'b0) begin
      bad++;
      $display("FAIL glitch_hi_end busy=%b q=%b exp 0 0", busy, q_level);
    end
    if (rise !== 1'b0) begin
      bad++;
      $display("FAIL glitch_hi_rise got=%b exp=0", rise);
    end
    test_pulse("accept_hi4", 1'b1, 4);
    test_pulse("glitch_lo3", 1'b0, 3);
    drive(1'b1);
    tick();
    total++;
    if (busy !== 1'b0 || q_level !== 1'b1 || fall !== 1'b0) begin
      bad++;
      $display("FAIL glitch_lo_end busy=%b q=%b fall=%b exp 0 1 0", busy, q_level, fall);
    end
    test_pulse("accept_lo4", 1'b0, 5);
  endtask

  task automatic test_back_to_back();
    test_pulse("b2b_hi", 1'b1, 4);
    // din drops right after the accepting edge: fresh fall candidate
    drive(1'b0);
    tick();
    total += 2;
    if (busy !== 1'b1 || q_level !== 1'b1) begin
      bad++;
      $display("FAIL b2b_cand busy=%b q=%b exp 1 1", busy, q_level);
    end
    if (rise !== 1'b0 || fall !== 1'b0) begin
      bad++;
      $display("FAIL b2b_strobe rise=%b fall=%b exp 0 0", rise, fall);
    end
    for (int e = 2; e <= 4; e++) tick();
    total++;
    if (fall !== 1'b1 || q_level !== 1'b0) begin
      bad++;
      $display("FAIL b2b_fall fall=%b q=%b exp 1 0", fall, q_level);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1);
    tick();
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy got=%b exp=1", busy);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || q_level !== 1'b0 || rise !== 1'b0) begin
      bad++;
      $display("FAIL mid_abort busy=%b q=%b rise=%b exp 0 0 0", busy, q_level, rise);
    end
    test_pulse("mid_rerun", 1'b1, 5);
  endtask

  task automatic test_chained();
    int rises;
    int falls;
    rises = 0;
    falls = 0;
    @(negedge clk);
    chain = 1'b1;
    d = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      d = (c >= 5 && c < 10) || (c >= 15);
      tick();
      if (c < 16) begin
        rises += int'(rise);
        falls += int'(fall);
      end
      total++;
      if (q_level !== sh[3]) begin
        bad++;
        $display("FAIL chain_lag cyc=%0d got=%b exp=%b", c, q_level, sh[3]);
      end
    end
    total += 2;
    if (rises != 1) begin
      bad++;
      $display("FAIL chain_rises got=%0d exp=1", rises);
    end
    if (falls != 1) begin
      bad++;
      $display("FAIL chain_falls got=%0d exp=1", falls);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    chain = 1'b0;
    d = 1'b0;
    din = 1'b0;
    reset = 1'b1;
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_chained();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
